// File: rtl/enc8_pkg.sv
// Shared types and constants for the serial 8-to-3 encoder.
package enc8_pkg;

    localparam int N    = 8;
    localparam int IDXW = $clog2(N);

    typedef enum logic {IDLE, SCAN} enc_state_t;
    typedef logic [IDXW-1:0] enc_idx_t;

    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    // True when exactly one bit of v is set.
    function automatic logic is_single(input logic [N-1:0] v);
        return (v != '0) && ((v & (v - ONE)) == '0);
    endfunction

endpackage

// File: rtl/prio_enc8.sv
// Combinational priority finder over the pending vector.
// ENC8_MSB_FIRST_EN selects highest-set-bit priority; default is lowest-set-bit.
module prio_enc8
    import enc8_pkg::*;
(
    input  logic [N-1:0] pending,
    output logic         found,
    output enc_idx_t     idx
);

    always_comb begin
        found = |pending;
        idx   = '0;
`ifdef ENC8_MSB_FIRST_EN
        for (int i = 0; i < N; i++) begin
            if (pending[i]) idx = enc_idx_t'(i);
        end
`else
        // Walk downwards so the last hit, the lowest set bit, wins.
        for (int i = N - 1; i >= 0; i--) begin
            if (pending[i]) idx = enc_idx_t'(i);
        end
`endif
    end

endmodule

// File: rtl/enc8to3_serial.sv
// Serial 8-to-3 encoder: accepts a multi-hot word and streams the index of each set bit.
// Scan direction follows ENC8_MSB_FIRST_EN (see prio_enc8).
module enc8to3_serial
    import enc8_pkg::*;
(
    input  logic         Clock,
    input  logic         Resetn,
    input  logic         In_valid,
    output logic         In_ready,
    input  logic [N-1:0] W,
    output logic         Out_valid,
    input  logic         Out_ready,
    output enc_idx_t     Y,
    output logic         Last,
    output logic         Zero
);

    enc_state_t   state_q, state_d;
    logic [N-1:0] pending_q, pending_d;
    logic         zero_q, zero_d;

    logic         found;
    enc_idx_t     idx;

    prio_enc8 u_prio (
        .pending (pending_q),
        .found   (found),
        .idx     (idx)
    );

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q   <= IDLE;
            pending_q <= '0;
            zero_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            zero_q    <= zero_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        zero_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (In_valid) begin
                    if (W != '0) begin
                        pending_d = W;
                        state_d   = SCAN;
                    end else begin
                        zero_d = 1'b1;
                    end
                end
            end
            SCAN: begin
                if (Out_ready && found) begin
                    pending_d = pending_q & ~(ONE << idx);
                    if (is_single(pending_q)) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Y needs no gating: pending is empty outside SCAN, so the finder yields 0.
    assign Out_valid = (state_q == SCAN);
    assign In_ready  = (state_q == IDLE);
    assign Y         = idx;
    assign Last      = (state_q == SCAN) && is_single(pending_q);
    assign Zero      = zero_q;

endmodule

// File: tb/tb_enc8to3_serial.sv
// Self-checking bench for enc8to3_serial: queue-based reference model plus directed literal checks.
module tb_enc8to3_serial;

    logic       Clock = 1'b0;
    logic       Resetn = 1'b0;
    logic       In_valid = 1'b0;
    logic       In_ready;
    logic [7:0] W = 8'h00;
    logic       Out_valid;
    logic       Out_ready = 1'b0;
    logic [2:0] Y;
    logic       Last;
    logic       Zero;

    int errors = 0;
    int checks = 0;

    int q[$];
    bit exp_zero = 1'b0;

    int got[$];
    int got_last[$];
    int zero_cnt = 0;
    int ov_cnt = 0;

    enc8to3_serial dut (
        .Clock     (Clock),
        .Resetn    (Resetn),
        .In_valid  (In_valid),
        .In_ready  (In_ready),
        .W         (W),
        .Out_valid (Out_valid),
        .Out_ready (Out_ready),
        .Y         (Y),
        .Last      (Last),
        .Zero      (Zero)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_seq(input string name, input int exp[$]);
        chk({name, "_len"}, got.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got.size(); i++)
            chk($sformatf("%s_y%0d", name, i), got[i], exp[i]);
        if (got_last.size() > 0) begin
            chk({name, "_last_final"}, got_last[got_last.size()-1], 1);
            chk({name, "_last_count"}, got_last.sum(), 1);
        end
    endtask

    function automatic void load_model(input logic [7:0] w);
`ifdef ENC8_MSB_FIRST_EN
        for (int i = 7; i >= 0; i--) if (w[i]) q.push_back(i);
`else
        for (int i = 0; i < 8; i++) if (w[i]) q.push_back(i);
`endif
    endfunction

    // One cycle: compare outputs at negedge, then drive inputs and advance the model.
    task automatic step(input logic iv, input logic [7:0] w, input logic ordy);
        int exp_v;
        int act_v;
        bit ov;
        @(negedge Clock);
        ov    = (q.size() > 0);
        exp_v = {ov, !ov, (ov ? q[0][2:0] : 3'd0), (q.size() == 1), exp_zero};
        act_v = {Out_valid, In_ready, Y, Last, Zero};
        chk("cycle", act_v, exp_v);
        if (Zero) zero_cnt++;
        if (Out_valid) ov_cnt++;
        if (Out_valid && ordy) begin
            got.push_back(int'(Y));
            got_last.push_back(int'(Last));
        end
        In_valid  = iv;
        W         = w;
        Out_ready = ordy;
        if (!ov) begin
            exp_zero = iv && (w == 8'h00);
            if (iv && w != 8'h00) load_model(w);
        end else begin
            exp_zero = 1'b0;
            if (ordy) void'(q.pop_front());
        end
    endtask

    task automatic do_reset_mid();
        @(negedge Clock);
        Resetn = 1'b0;
        In_valid = 1'b0;
        W = 8'h00;
        Out_ready = 1'b0;
        #1;
        chk("rst_out_valid", int'(Out_valid), 0);
        chk("rst_in_ready", int'(In_ready), 1);
        chk("rst_y", int'(Y), 0);
        chk("rst_last", int'(Last), 0);
        chk("rst_zero", int'(Zero), 0);
        q.delete();
        exp_zero = 1'b0;
        @(negedge Clock);
        Resetn = 1'b1;
    endtask

    initial begin
        int n;
        int z0;
        int ov0;
        int exp_q[$];

        // Reset state
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        chk("init_in_ready", int'(In_ready), 1);
        chk("init_out_valid", int'(Out_valid), 0);
        chk("init_y", int'(Y), 0);
        chk("init_last", int'(Last), 0);
        chk("init_zero", int'(Zero), 0);
        Resetn = 1'b1;

        // Test 1: sparse vector, continuous Out_ready
        got.delete(); got_last.delete();
        step(1, 8'b1010_0100, 1);
        repeat (3) step(0, 8'h00, 1);
        step(0, 8'h00, 0);
        chk("t1_in_ready_after", int'(In_ready), 1);
`ifdef ENC8_MSB_FIRST_EN
        exp_q = '{7, 5, 2};
`else
        exp_q = '{2, 5, 7};
`endif
        check_seq("t1", exp_q);

        // Test 2: all-zero vector gives a single Zero pulse, no output
        z0 = zero_cnt; ov0 = ov_cnt;
        step(1, 8'h00, 0);
        repeat (3) step(0, 8'h00, 0);
        chk("t2_zero_pulses", zero_cnt - z0, 1);
        chk("t2_no_out_valid", ov_cnt - ov0, 0);
        chk("t2_in_ready", int'(In_ready), 1);

        // Test 3: backpressure holds Y stable
        got.delete(); got_last.delete();
        step(1, 8'b0001_0001, 0);
        repeat (3) step(0, 8'h00, 0);
        repeat (2) step(0, 8'h00, 1);
        step(0, 8'h00, 0);
`ifdef ENC8_MSB_FIRST_EN
        exp_q = '{4, 0};
`else
        exp_q = '{0, 4};
`endif
        check_seq("t3", exp_q);

        // Test 4: reset mid-scan discards the vector
        got.delete(); got_last.delete();
        step(1, 8'hFF, 1);
        repeat (3) step(0, 8'h00, 1);
        do_reset_mid();
        got.delete(); got_last.delete();
        step(1, 8'h80, 1);
        step(0, 8'h00, 1);
        step(0, 8'h00, 0);
        step(0, 8'h00, 0);
        exp_q = '{7};
        check_seq("t4", exp_q);

        // Test 5: full vector, count cycles from capture back to In_ready
        got.delete(); got_last.delete();
        step(1, 8'hFF, 1);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            step(0, 8'h00, 1);
            n++;
            if (In_ready) break;
        end
        chk("t5_capture_to_ready", n, 9);
`ifdef ENC8_MSB_FIRST_EN
        exp_q = '{7, 6, 5, 4, 3, 2, 1, 0};
`else
        exp_q = '{0, 1, 2, 3, 4, 5, 6, 7};
`endif
        check_seq("t5", exp_q);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            logic       iv;
            logic [7:0] w;
            logic       ordy;
            iv   = ($urandom_range(0, 2) != 0);
            w    = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
            ordy = ($urandom_range(0, 3) != 0);
            step(iv, w, ordy);
        end
        repeat (12) step(0, 8'h00, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
